// File: rtl/decode_stage.sv
// MIPS ID stage: register file, control decode, load-use hazard
// detection and the ID/EX pipeline register.
package decode_pkg;
  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sext;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_ex_t;
endpackage

module decode_stage
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_instruction,
  input  logic [31:0] in_incremented_PC,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        flush,
  output logic        pc_write,
  output logic        if_id_write,
  output logic [1:0]  out_WB,
  output logic [2:0]  out_M,
  output logic [3:0]  out_EX,
  output logic [31:0] out_incremented_PC,
  output logic [31:0] out_regData1,
  output logic [31:0] out_regData2,
  output logic [31:0] out_sign_extended_offset,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd
);

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rf_q [32];
  logic        wr_en;
  logic [31:0] rd1, rd2;
  logic [8:0]  ctl;
  logic        stall, bubble;
  id_ex_t      idex_d, idex_q;

  assign opcode = in_instruction[31:26];
  assign rs     = in_instruction[25:21];
  assign rt     = in_instruction[20:16];
  assign rd     = in_instruction[15:11];
  assign wr_en  = wb_reg_write && (wb_write_reg != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[wb_write_reg] <= wb_write_data;
    end
  end

  // Write-through so a same-cycle write-back needs no stall
  always_comb begin
    rd1 = rf_q[rs];
    rd2 = rf_q[rt];
    if (wr_en && wb_write_reg == rs) rd1 = wb_write_data;
    if (wr_en && wb_write_reg == rt) rd2 = wb_write_data;
    if (rs == 5'd0) rd1 = '0;
    if (rt == 5'd0) rd2 = '0;
  end

  // ctl = {WB[1:0], M[2:0], EX[3:0]}
  always_comb begin
    ctl = '0;
    unique case (1'b1)
      opcode == 6'h00: ctl = 9'b10_000_1010;
      opcode == 6'h23: ctl = 9'b11_010_0001;
      opcode == 6'h2B: ctl = 9'b00_001_0001;
      opcode == 6'h04: ctl = 9'b00_100_0100;
      opcode == 6'h08: ctl = 9'b10_000_0001;
      default:         ctl = '0;
    endcase
  end

  assign stall = ex_mem_read && (ex_rt != 5'd0) &&
                 ((ex_rt == rs) || (ex_rt == rt));
  assign bubble      = stall || flush;
  assign pc_write    = flush || !stall;
  assign if_id_write = flush || !stall;

  always_comb begin
    idex_d      = '0;
    idex_d.wb   = bubble ? 2'b0 : ctl[8:7];
    idex_d.m    = bubble ? 3'b0 : ctl[6:4];
    idex_d.ex   = bubble ? 4'b0 : ctl[3:0];
    idex_d.pc4  = in_incremented_PC;
    idex_d.rd1  = rd1;
    idex_d.rd2  = rd2;
    idex_d.sext = {{16{in_instruction[15]}}, in_instruction[15:0]};
    idex_d.rs   = rs;
    idex_d.rt   = rt;
    idex_d.rd   = rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign out_WB                   = idex_q.wb;
  assign out_M                    = idex_q.m;
  assign out_EX                   = idex_q.ex;
  assign out_incremented_PC       = idex_q.pc4;
  assign out_regData1             = idex_q.rd1;
  assign out_regData2             = idex_q.rd2;
  assign out_sign_extended_offset = idex_q.sext;
  assign out_rs                   = idex_q.rs;
  assign out_rt                   = idex_q.rt;
  assign out_rd                   = idex_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed steps then random
// traffic against a behavioural model of the decode rules.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_instruction, in_incremented_PC;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        flush;
  logic        pc_write, if_id_write;
  logic [1:0]  out_WB;
  logic [2:0]  out_M;
  logic [3:0]  out_EX;
  logic [31:0] out_incremented_PC, out_regData1, out_regData2;
  logic [31:0] out_sign_extended_offset;
  logic [4:0]  out_rs, out_rt, out_rd;

  int vecs = 0;
  int errs = 0;
  logic [31:0] mem [32];

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_instruction(in_instruction),
    .in_incremented_PC(in_incremented_PC),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
    .wb_write_data(wb_write_data),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush(flush),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .out_WB(out_WB), .out_M(out_M), .out_EX(out_EX),
    .out_incremented_PC(out_incremented_PC),
    .out_regData1(out_regData1), .out_regData2(out_regData2),
    .out_sign_extended_offset(out_sign_extended_offset),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ctl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1010;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0100;
      6'h08:   return 9'b10_000_0001;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_reg_write && wb_write_reg == a) return wb_write_data;
    return mem[a];
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {23'd0, out_WB, out_M, out_EX}, 32'd0);
    check({tag, "_pc"}, out_incremented_PC, 32'd0);
    check({tag, "_d1"}, out_regData1, 32'd0);
    check({tag, "_d2"}, out_regData2, 32'd0);
    check({tag, "_sx"}, out_sign_extended_offset, 32'd0);
    check({tag, "_regs"}, {17'd0, out_rs, out_rt, out_rd}, 32'd0);
  endtask

  // Drives one decode cycle starting just after a rising edge.
  task automatic step(input string tag, input logic [31:0] ins,
                      input logic [31:0] pc, input logic we,
                      input logic [4:0] wr, input logic [31:0] wd,
                      input logic emr, input logic [4:0] ert,
                      input logic fl);
    logic        hz;
    logic [8:0]  c;
    logic [31:0] e1, e2;
    in_instruction = ins; in_incremented_PC = pc;
    wb_reg_write = we; wb_write_reg = wr; wb_write_data = wd;
    ex_mem_read = emr; ex_rt = ert; flush = fl;
    #1;
    hz = emr && ert != 0 && (ert == ins[25:21] || ert == ins[20:16]);
    check({tag, "_pcw"}, {31'd0, pc_write}, {31'd0, fl || !hz});
    check({tag, "_ifw"}, {31'd0, if_id_write}, {31'd0, fl || !hz});
    c  = (hz || fl) ? 9'd0 : ctl_of(ins[31:26]);
    e1 = rd_model(ins[25:21]);
    e2 = rd_model(ins[20:16]);
    @(posedge clk);
    if (we && wr != 0) mem[wr] = wd;
    #1;
    check({tag, "_ctl"}, {23'd0, out_WB, out_M, out_EX}, {23'd0, c});
    check({tag, "_pc"}, out_incremented_PC, pc);
    check({tag, "_d1"}, out_regData1, e1);
    check({tag, "_d2"}, out_regData2, e2);
    check({tag, "_sx"}, out_sign_extended_offset,
          32'(signed'(ins[15:0])));
    check({tag, "_regs"}, {17'd0, out_rs, out_rt, out_rd},
          {17'd0, ins[25:11]});
  endtask

  localparam logic [31:0] NOP = 32'hFC00_0000;

  initial begin
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
    foreach (mem[i]) mem[i] = '0;
    rst_n = 1'b0;
    in_instruction = '0; in_incremented_PC = '0;
    wb_reg_write = 0; wb_write_reg = '0; wb_write_data = '0;
    ex_mem_read = 0; ex_rt = '0; flush = 0;
    #2;
    check_zero("rst0");
    check("rst0_pcw", {31'd0, pc_write}, 32'd1);
    check("rst0_ifw", {31'd0, if_id_write}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    step("wr1", NOP, 32'h4, 1, 5'd1, 32'd7, 0, 5'd0, 0);
    step("wr2", NOP, 32'h8, 1, 5'd2, 32'd9, 0, 5'd0, 0);
    step("add", 32'h0022_1820, 32'hC, 0, 5'd0, 0, 0, 5'd0, 0);
    step("lw", 32'h8C24_FFF8, 32'h10, 0, 5'd0, 0, 0, 5'd0, 0);
    step("luse", 32'h0081_2820, 32'h14, 0, 5'd0, 0, 1, 5'd4, 0);
    step("issue", 32'h0081_2820, 32'h14, 0, 5'd0, 0, 0, 5'd0, 0);
    step("byp", 32'h00C0_3820, 32'h18, 1, 5'd6, 32'hDEAD, 0, 5'd0, 0);
    step("r0w", NOP, 32'h1C, 1, 5'd0, 32'h1234, 0, 5'd0, 0);
    step("r0r", 32'h0000_3820, 32'h20, 0, 5'd0, 0, 0, 5'd0, 0);
    step("flst", 32'h0081_2820, 32'h24, 0, 5'd0, 0, 1, 5'd4, 1);
    step("sw", 32'hAC66_0010, 32'h28, 0, 5'd0, 0, 0, 5'd0, 0);

    #3 rst_n = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    #1 check_zero("rstm");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step("r5", 32'h00A0_0000, 32'h30, 0, 5'd0, 0, 0, 5'd0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(5)];
      ins[25:21] = 5'($urandom_range(7));
      ins[20:16] = 5'($urandom_range(7));
      step("rnd", ins, $urandom, 1'($urandom), 5'($urandom_range(7)),
           $urandom, ($urandom_range(2) == 0), 5'($urandom_range(7)),
           ($urandom_range(5) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the five-stage MIPS pipeline. It sits between the IF/ID register (fetch) and the execute stage. It holds the 32x32 register file and the main control decoder, and it owns the ID/EX pipeline register, whose fields match the execute stage inputs bit for bit. It detects load-use hazards and inserts bubbles. It also clears its outputs on a taken-branch flush coming from the memory stage.

## Interface
- No parameters. Widths are fixed by the 32-bit MIPS datapath.
- clk  in  1  rising-edge clock. Sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_instruction  in  32  IF/ID instruction field (IF_ID[31:0]).
- in_incremented_PC  in  32  IF/ID PC+4 field (IF_ID[63:32]).
- wb_reg_write  in  1  register-file write enable from write-back.
- wb_write_reg  in  5  write-back destination register.
- wb_write_data  in  32  write-back data.
- ex_mem_read  in  1  M[1] of the instruction currently in EX (the ID/EX output loop-back).
- ex_rt  in  5  destination rt of the instruction currently in EX.
- flush  in  1  PCSrc from the memory stage (branch taken).
- pc_write  out  1  0 = hold PC.
- if_id_write  out  1  0 = hold IF/ID.
- out_WB  out  2  [1] RegWrite, [0] MemtoReg.
- out_M  out  3  [2] Branch, [1] MemRead, [0] MemWrite.
- out_EX  out  4  [3:2] ALUOp, [1] RegDst, [0] ALUSrc.
- out_incremented_PC  out  32  registered PC+4.
- out_regData1  out  32  rs value.
- out_regData2  out  32  rt value.
- out_sign_extended_offset  out  32  sign-extended instr[15:0].
- out_rs  out  5  instr[25:21], passed on for forwarding.
- out_rt  out  5  instr[20:16].
- out_rd  out  5  instr[15:11].

## Operation
**Field extraction:** opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11].

**Control decode.** Each opcode maps to {WB, M, EX}:
- R-type (0x00): WB = 10, M = 000, EX = 1010.
- lw (0x23): WB = 11, M = 010, EX = 0001.
- sw (0x2B): WB = 00, M = 001, EX = 0001.
- beq (0x04): WB = 00, M = 100, EX = 0100.
- addi (0x08): WB = 10, M = 000, EX = 0001.
- Any other opcode: all-zero control (NOP).

**Register file.**
- 32 x 32 bits. r0 reads 0 at all times and is never written.
- Write on rising clk when wb_reg_write = 1 and wb_write_reg != 0.
- Reads are combinational, with write-through bypass: if wb_reg_write = 1, wb_write_reg != 0 and wb_write_reg equals the read address, the read returns wb_write_data in the same cycle.
- Reset clears all registers to 0.

**Hazard detection (combinational).**
- stall = ex_mem_read & (ex_rt != 0) & (ex_rt == rs | ex_rt == rt).
- While stall = 1: pc_write = 0 and if_id_write = 0. The next ID/EX load takes all-zero control (bubble) and data fields load normally.

**Flush.**
- flush = 1 has priority over stall.
- pc_write = 1 and if_id_write = 1, so fetch can take the branch target.
- The next ID/EX load takes all-zero control. Clearing IF/ID is fetch's job.

**ID/EX register.** Loads every rising clk; it has no enable.
- Control fields load the decoded values, or zero on a bubble or flush.
- Data fields load the current decode values.

## Timing
- Decode to ID/EX outputs: 1 cycle, registered on rising clk.
- pc_write and if_id_write are combinational within the same cycle. They depend on in_instruction, ex_mem_read, ex_rt and flush.
- Load-use: exactly one bubble per hazard. In the following cycle the lw has left EX (ex_mem_read now reflects the bubble = 0), so the held instruction issues.
- Write-back in the same cycle as a decode read of the same register: the new value is seen through the bypass; there is no extra stall.
- Asynchronous reset asserted (rst_n low), including mid-stall or mid-flush:
  - All ID/EX outputs go to 0 immediately and all registers clear.
  - pc_write and if_id_write follow their combinational equations. With all-zero control inputs this gives 1.
- On release, the first rising clk loads normally.
- Simultaneous stall and flush: flush behaviour only.

## Test plan
- **Reset:** rst_n = 0 mid-cycle with non-zero outputs -> all outputs 0 at once; reading r5 after release returns 0.
- **R-type decode:** r1 = 7, r2 = 9, add r3,r1,r2 (0x00221820) -> next cycle out_WB = 10, out_EX = 1010, out_regData1 = 7, out_regData2 = 9, out_rd = 3.
- **lw decode:** lw r4,-8(r1) -> out_sign_extended_offset = 0xFFFFFFF8, out_M = 010, out_WB = 11.
- **Load-use:** ex_mem_read = 1, ex_rt = 4, decoding add r5,r4,r1 -> pc_write = 0 and if_id_write = 0 for one cycle, then a bubble (control 0), then the add issues.
- **Bypass and r0:**
  - wb write r6 = 0xDEAD while decoding a read of r6 -> out_regData1 = 0xDEAD.
  - A write to r0 is ignored; a later read of r0 returns 0.
- **Flush over stall:** flush = 1 together with a hazard -> pc_write = 1, if_id_write = 1, next ID/EX control all zero.
